// File: rtl/lcd_bus_ctrl_if.sv
// lcd_bus_ctrl_if
//   Bundles the host byte handshake, the controller status and the LCD pins
//   used by lcd_bus_ctrl.
// Signals:
//   in_data[7:0]   command or data byte offered by the host
//   in_rs          0 = command, 1 = data
//   in_valid       host offers a byte
//   in_ready       controller accepts the byte on this clk edge
//   busy           controller active or bytes queued
//   fifo_level     number of queued bytes
//   lcd_rs         LCD register select
//   lcd_en         LCD enable strobe
//   lcd_data_bus   LCD data pins (8 or 4 wide)
// Modports:
//   master  host side (drives in_data/in_rs/in_valid)
//   slave   controller side (drives everything else)
interface lcd_bus_ctrl_if #(
  parameter int BUS_WIDTH  = 8,
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                  in_data;
  logic                        in_rs;
  logic                        in_valid;
  logic                        in_ready;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        lcd_rs;
  logic                        lcd_en;
  logic [BUS_WIDTH-1:0]        lcd_data_bus;

  modport master (
    output in_data, in_rs, in_valid,
    input  in_ready, busy, fifo_level, lcd_rs, lcd_en, lcd_data_bus
  );

  modport slave (
    input  in_data, in_rs, in_valid,
    output in_ready, busy, fifo_level, lcd_rs, lcd_en, lcd_data_bus
  );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl
//   HD44780-style LCD write sequencer. Bytes from the host are queued, then
//   each is driven to the LCD as SETUP -> PULSE (EN high) -> HOLD, once for an
//   8-bit bus or twice (high nibble, then low nibble) for a 4-bit bus,
//   followed by an EXEC wait. Clear/home commands get the long wait.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   lcd_bus_ctrl_if.slave (host handshake, status, LCD pins)
// Configuration:
//   LCD_FIFO_EN  defined   -> FIFO_DEPTH-entry byte queue
//                undefined -> single holding register, FIFO_DEPTH ignored
module lcd_bus_ctrl #(
  parameter int BUS_WIDTH        = 8,
  parameter int SETUP_CYCLES     = 2,
  parameter int EN_HIGH_CYCLES   = 25,
  parameter int HOLD_CYCLES      = 2,
  parameter int EXEC_CYCLES      = 2000,
  parameter int LONG_EXEC_CYCLES = 82000,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic          clk,
  input  logic          rst,
  lcd_bus_ctrl_if.slave bus
);

  localparam int LW      = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX = (LONG_EXEC_CYCLES > EN_HIGH_CYCLES) ? LONG_EXEC_CYCLES : EN_HIGH_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Counter loads are N-1: a state lasts N cycles and exits when cnt hits 0.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_EXEC_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic                 pop;
  logic [7:0]           q_data;
  logic                 q_rs;
  logic [LW-1:0]        level;
  logic                 rs_q;
  logic                 en_q;
  logic [BUS_WIDTH-1:0] data_q;
  logic [BUS_WIDTH-1:0] pend_xfer;
  logic [BUS_WIDTH-1:0] first_xfer;
  logic [BUS_WIDTH-1:0] second_xfer;
  logic                 low_pending;
  logic                 long_exec;
  logic                 is_long;

`ifdef LCD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_data [FIFO_DEPTH];
  logic          mem_rs   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;

  assign bus.in_ready = (level != LW'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == S_IDLE) && (level != '0);
  assign q_data       = mem_data[rd_ptr];
  assign q_rs         = mem_rs[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.in_data;
      mem_rs[wr_ptr]   <= bus.in_rs;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
`else
  logic [7:0] hold_data;
  logic       hold_rs;
  logic       hold_full;
  logic       push;

  // Ready only in IDLE with nothing held, and never while reset is applied.
  assign bus.in_ready = !rst && (state == S_IDLE) && !hold_full;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == S_IDLE) && hold_full;
  assign q_data       = hold_data;
  assign q_rs         = hold_rs;
  assign level        = LW'(hold_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_rs   <= 1'b0;
      hold_full <= 1'b0;
    end else if (push) begin
      hold_data <= bus.in_data;
      hold_rs   <= bus.in_rs;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end
`endif

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_long = !q_rs && (q_data[7:2] == 6'b000000) && (q_data[1:0] != 2'b00);

  generate
    if (BUS_WIDTH == 4) begin : g_nibble
      assign first_xfer  = q_data[7:4];
      assign second_xfer = q_data[3:0];
    end else begin : g_byte
      assign first_xfer  = q_data;
      assign second_xfer = q_data;
    end
  endgenerate

  assign bus.lcd_rs       = rs_q;
  assign bus.lcd_en       = en_q;
  assign bus.lcd_data_bus = data_q;
  assign bus.fifo_level   = level;
  assign bus.busy         = (state != S_IDLE) || (level != '0);

  // lcd_rs/lcd_data_bus only change when a byte is popped or when the low
  // nibble replaces the high one, so they stay put through SETUP..HOLD and idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= '0;
      pend_xfer   <= '0;
      low_pending <= 1'b0;
      long_exec   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            rs_q        <= q_rs;
            data_q      <= first_xfer;
            pend_xfer   <= second_xfer;
            low_pending <= (BUS_WIDTH == 4);
            long_exec   <= is_long;
            cnt         <= SETUP_LD;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            en_q  <= 1'b1;
            cnt   <= EN_LD;
            state <= S_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            en_q  <= 1'b0;
            cnt   <= HOLD_LD;
            state <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (low_pending) begin
            low_pending <= 1'b0;
            data_q      <= pend_xfer;
            cnt         <= SETUP_LD;
            state       <= S_SETUP;
          end else begin
            cnt   <= long_exec ? LONG_LD : EXEC_LD;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          en_q  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl
//   Drives an 8-bit-bus and a 4-bit-bus lcd_bus_ctrl side by side. Every
//   accepted byte pushes the transfers it must produce into a per-instance
//   queue; a monitor pops and compares at each rising lcd_en, and checks the
//   pulse width and pin stability. Timing is checked from lcd_en rise cycles
//   and from when busy drops.
module tb_lcd_bus_ctrl;

  localparam int SETUP  = 2;
  localparam int EN_HI  = 4;
  localparam int HOLD   = 2;
  localparam int EXEC   = 10;
  localparam int LEXEC  = 30;
  localparam int DEPTH  = 4;

`ifdef LCD_FIFO_EN
  localparam int RDY_IN_RST = 1;
  localparam int GAP_EXTRA  = 0;
`else
  localparam int RDY_IN_RST = 0;
  localparam int GAP_EXTRA  = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   testsRun = 0;
  int   failCount = 0;

  lcd_bus_ctrl_if #(.BUS_WIDTH(8), .FIFO_DEPTH(DEPTH)) if8 ();
  lcd_bus_ctrl_if #(.BUS_WIDTH(4), .FIFO_DEPTH(DEPTH)) if4 ();

  lcd_bus_ctrl #(
    .BUS_WIDTH(8), .SETUP_CYCLES(SETUP), .EN_HIGH_CYCLES(EN_HI), .HOLD_CYCLES(HOLD),
    .EXEC_CYCLES(EXEC), .LONG_EXEC_CYCLES(LEXEC), .FIFO_DEPTH(DEPTH)
  ) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  lcd_bus_ctrl #(
    .BUS_WIDTH(4), .SETUP_CYCLES(SETUP), .EN_HIGH_CYCLES(EN_HI), .HOLD_CYCLES(HOLD),
    .EXEC_CYCLES(EXEC), .LONG_EXEC_CYCLES(LEXEC), .FIFO_DEPTH(DEPTH)
  ) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [8:0] exp8 [$];
  logic [8:0] exp4 [$];
  int         rise8 [$];
  int         rise4 [$];
  logic       en8Prev = 1'b0;
  logic       en4Prev = 1'b0;
  int         hi8 = 0;
  int         hi4 = 0;
  logic [8:0] snap8;
  logic [8:0] snap4;
  logic       sawFull = 1'b0;

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      en8Prev = 1'b0;
      hi8     = 0;
    end else begin
      if (if8.lcd_en && !en8Prev) begin
        snap8 = {if8.lcd_rs, if8.lcd_data_bus};
        hi8   = 1;
        rise8.push_back(cyc);
        if (exp8.size() == 0) checkOutput("sb_underflow8", 32'(exp8.size()), 1);
        else                  checkOutput("xfer8", 32'(snap8), 32'(exp8.pop_front()));
      end else if (if8.lcd_en) begin
        hi8++;
        checkOutput("stable8", 32'({if8.lcd_rs, if8.lcd_data_bus}), 32'(snap8));
      end else if (en8Prev) begin
        checkOutput("en_width8", hi8, EN_HI);
      end
      en8Prev = if8.lcd_en;
`ifdef LCD_FIFO_EN
      if (if8.fifo_level == 3'd4) begin
        sawFull = 1'b1;
        checkOutput("ready_full8", 32'(if8.in_ready), 0);
      end
`endif
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      en4Prev = 1'b0;
      hi4     = 0;
    end else begin
      if (if4.lcd_en && !en4Prev) begin
        snap4 = {if4.lcd_rs, 4'h0, if4.lcd_data_bus};
        hi4   = 1;
        rise4.push_back(cyc);
        if (exp4.size() == 0) checkOutput("sb_underflow4", 32'(exp4.size()), 1);
        else                  checkOutput("xfer4", 32'(snap4), 32'(exp4.pop_front()));
      end else if (if4.lcd_en) begin
        hi4++;
        checkOutput("stable4", 32'({if4.lcd_rs, 4'h0, if4.lcd_data_bus}), 32'(snap4));
      end else if (en4Prev) begin
        checkOutput("en_width4", hi4, EN_HI);
      end
      en4Prev = if4.lcd_en;
    end
  end

  // Offer one byte, wait (bounded) for in_ready, record expected transfers.
  task automatic applyStimulus(input bit sel, input logic rs, input logic [7:0] d, output int acc);
    int   n = 0;
    logic rdy;
    @(negedge clk);
    if (sel) begin if4.in_data = d; if4.in_rs = rs; if4.in_valid = 1'b1; end
    else     begin if8.in_data = d; if8.in_rs = rs; if8.in_valid = 1'b1; end
    rdy = sel ? if4.in_ready : if8.in_ready;
    while (!rdy && n < 400) begin
      @(negedge clk);
      n++;
      rdy = sel ? if4.in_ready : if8.in_ready;
    end
    acc = cyc;
    if (!rdy) begin
      checkOutput("ready_timeout", 32'(rdy), 1);
    end else if (sel) begin
      exp4.push_back({rs, 4'h0, d[7:4]});
      exp4.push_back({rs, 4'h0, d[3:0]});
    end else begin
      exp8.push_back({rs, d});
    end
    @(posedge clk);
    #1;
    if (sel) if4.in_valid = 1'b0;
    else     if8.in_valid = 1'b0;
  endtask

  task automatic waitIdle(input bit sel, output int c);
    int   n = 0;
    logic bsy;
    @(negedge clk);
    bsy = sel ? if4.busy : if8.busy;
    while (bsy && n < 600) begin
      @(negedge clk);
      n++;
      bsy = sel ? if4.busy : if8.busy;
    end
    c = cyc;
    if (bsy) checkOutput("idle_timeout", 32'(bsy), 0);
  endtask

  task automatic checkResetState(input string tag, input int rdyExp);
    checkOutput({tag, "_en8"},    32'(if8.lcd_en), 0);
    checkOutput({tag, "_rs8"},    32'(if8.lcd_rs), 0);
    checkOutput({tag, "_data8"},  32'(if8.lcd_data_bus), 0);
    checkOutput({tag, "_busy8"},  32'(if8.busy), 0);
    checkOutput({tag, "_level8"}, 32'(if8.fifo_level), 0);
    checkOutput({tag, "_rdy8"},   32'(if8.in_ready), 32'(rdyExp));
    checkOutput({tag, "_en4"},    32'(if4.lcd_en), 0);
    checkOutput({tag, "_data4"},  32'(if4.lcd_data_bus), 0);
    checkOutput({tag, "_rdy4"},   32'(if4.in_ready), 32'(rdyExp));
  endtask

  logic [8:0] seq40 [5] = '{9'h001, 9'h00C, 9'h000, 9'h003, 9'h101};
  int         gap40 [4] = '{39, 19, 19, 39};

  initial begin
    int acc;
    int idle;
    int n;
    if8.in_data = '0; if8.in_rs = 1'b0; if8.in_valid = 1'b0;
    if4.in_data = '0; if4.in_rs = 1'b0; if4.in_valid = 1'b0;

    // Power-on reset.
    repeat (3) @(negedge clk);
    checkResetState("in_rst", RDY_IN_RST);
    rst = 1'b0;
    #1;
    checkResetState("post_rst", 1);

    // Single data byte on the 8-bit bus.
    applyStimulus(1'b0, 1'b1, 8'h41, acc);
    waitIdle(1'b0, idle);
    checkOutput("busy_time_41", idle - (acc + 1), 19);

    // Nibble pair on the 4-bit bus.
    rise4.delete();
    applyStimulus(1'b1, 1'b1, 8'hA5, acc);
    waitIdle(1'b1, idle);
    checkOutput("pulses_A5", rise4.size(), 2);
    checkOutput("nibble_gap_A5", rise4[1] - rise4[0], EN_HI + HOLD + SETUP);
    checkOutput("exec_A5", idle - rise4[1], EN_HI + HOLD + EXEC);

    // Long vs. normal EXEC, back to back.
    rise8.delete();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, seq40[i][8], seq40[i][7:0], acc);
    waitIdle(1'b0, idle);
    checkOutput("pulses_seq", rise8.size(), 5);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("gap_seq%0d", i), rise8[i+1] - rise8[i], gap40[i] + GAP_EXTRA);
    checkOutput("exec_seq_last", idle - rise8[4], EN_HI + HOLD + EXEC);

    // Six bytes offered continuously; queue fills and drains in order.
    rise8.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'(i), 8'(8'h30 + i), acc);
    waitIdle(1'b0, idle);
    checkOutput("pulses_six", rise8.size(), 6);
    checkOutput("sb_empty_six", exp8.size(), 0);
`ifdef LCD_FIFO_EN
    checkOutput("reached_full", 32'(sawFull), 1);
`endif

    // Reset in the second PULSE cycle, then a clean transfer.
    applyStimulus(1'b0, 1'b1, 8'h33, acc);
    n = 0;
    while (!if8.lcd_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pulse_seen_33", 32'(if8.lcd_en), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkResetState("mid_rst", RDY_IN_RST);
    exp8.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetState("after_mid_rst", 1);
    applyStimulus(1'b0, 1'b0, 8'h5A, acc);
    waitIdle(1'b0, idle);
    checkOutput("busy_time_5A", idle - (acc + 1), 19);

    checkOutput("sb_empty8", exp8.size(), 0);
    checkOutput("sb_empty4", exp4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lcd_bus_ctrl.md
LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8; LCD data bus width, legal values 8 or 4.
REQ-002 SHALL have parameter SETUP_CYCLES, default 2; cycles RS/data are stable before EN rises.
REQ-003 SHALL have parameter EN_HIGH_CYCLES, default 25; EN high width in cycles.
REQ-004 SHALL have parameter HOLD_CYCLES, default 2; cycles RS/data are held after EN falls.
REQ-005 SHALL have parameter EXEC_CYCLES, default 2000; post-byte wait for normal commands and data.
REQ-006 SHALL have parameter LONG_EXEC_CYCLES, default 82000; post-byte wait for clear/home commands.
REQ-007 SHALL have parameter FIFO_DEPTH, default 8; power of two, 2 or more.
REQ-008 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-009 SHALL have port rst, input, 1 bit; asynchronous reset, active-high.
REQ-010 SHALL have port in_data, input, 8 bits; command or data byte.
REQ-011 SHALL have port in_rs, input, 1 bit; 0 = command, 1 = data.
REQ-012 SHALL have port in_valid, input, 1 bit; byte offered.
REQ-013 SHALL have port in_ready, output, 1 bit; byte accepted when in_valid and in_ready are both high on a clk edge.
REQ-014 SHALL have port busy, output, 1 bit; high whenever the FSM is not in IDLE or a byte is queued.
REQ-015 SHALL have port lcd_rs, output, 1 bit; register select to the LCD.
REQ-016 SHALL have port lcd_en, output, 1 bit; enable strobe to the LCD.
REQ-017 SHALL have port lcd_data_bus, output, BUS_WIDTH bits; LCD data pins.
REQ-018 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits; number of queued bytes.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, EXEC, all driven by one down-counter sized for max(LONG_EXEC_CYCLES, EN_HIGH_CYCLES).
REQ-020 SHALL, in IDLE with a byte queued, pop it, drive lcd_rs and the first transfer on lcd_data_bus, and enter SETUP on the next cycle.
REQ-021 SHALL stay in SETUP for exactly SETUP_CYCLES cycles, PULSE for EN_HIGH_CYCLES cycles (lcd_en=1), and HOLD for HOLD_CYCLES cycles (lcd_en=0).
REQ-022 SHALL drive lcd_en high only in PULSE.
REQ-023 SHALL hold lcd_rs and lcd_data_bus constant from SETUP entry through HOLD exit.
REQ-024 SHALL, when BUS_WIDTH=8, drive the whole byte in one SETUP/PULSE/HOLD transfer.
REQ-025 SHALL, when BUS_WIDTH=4, send the high nibble first, then return from HOLD to SETUP with the low nibble and the same lcd_rs, then enter EXEC.
REQ-026 SHALL wait LONG_EXEC_CYCLES in EXEC when in_rs=0 and in_data[7:2]=6'b000000 with in_data is nonzero (0x01, 0x02, 0x03); otherwise it SHALL wait EXEC_CYCLES.
REQ-027 SHALL go from EXEC to IDLE, and SHALL start the next queued byte on the following cycle with no extra idle cycle.
REQ-028 SHALL drive in_ready=0 when the queue is full, and SHALL ignore an offered byte when in_ready=0, with no overwrite.
REQ-029 SHALL, when a push and a pop occur in the same cycle, perform both and leave fifo_level unchanged; a push into a full queue is impossible because in_ready=0.
REQ-030 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-031 SHALL keep lcd_rs and lcd_data_bus at their last values in IDLE.

Reset
REQ-032 SHALL, on rst high, immediately clear state to IDLE, lcd_en=0, lcd_rs=0, lcd_data_bus=0, counter=0, pointers=0, fifo_level=0, busy=0, regardless of the current state or byte.
REQ-033 SHALL drive in_ready=1 during and after reset when LCD_FIFO_EN is defined, and in_ready=1 after reset release when it is not.
REQ-034 SHALL discard a byte in progress when rst occurs mid-transfer, with no completion of the pulse.

Configuration
REQ-035 SHALL, with macro LCD_FIFO_EN defined, queue up to FIFO_DEPTH bytes as specified.
REQ-036 SHALL, without LCD_FIFO_EN, replace the FIFO with a single holding register: in_ready=1 only in IDLE with the register empty, fifo_level is 0 or 1, and FIFO_DEPTH is ignored.

Verification
REQ-037 Bench SHALL use SETUP=2, EN_HIGH=4, HOLD=2, EXEC=10, LONG_EXEC=30 unless a line states otherwise.
REQ-038 BUS_WIDTH=8, push (rs=1, 0x41) -> lcd_rs=1, bus=0x41, en high exactly 4 cycles, busy low 19 cycles after acceptance.
REQ-039 BUS_WIDTH=4, push (rs=1, 0xA5) -> two en pulses with bus=4'hA then 4'h5, rs=1 both, then a 10-cycle EXEC.
REQ-040 Push (rs=0, 0x01) then (rs=0, 0x0C) -> 30-cycle wait after the first byte, 10-cycle wait after the second, back-to-back with no gap.
REQ-041 LCD_FIFO_EN, FIFO_DEPTH=4, push 6 bytes continuously -> in_ready drops once fifo_level=4, all 6 bytes appear on the bus in order, none lost or duplicated.
REQ-042 Assert rst in the 2nd PULSE cycle -> lcd_en=0 at once, all outputs at reset values, the next pushed byte is transferred cleanly.
